fetch1: RTL

- First fetch stage of the dual-issue front end.
- Owns the fetch PC and drives the instruction-memory address each cycle. The memory is synchronous and returns a 64-bit, two-instruction packet to fetch2 one cycle later.
- Applies redirects from the branch unit and decode, and follows taken predictions from an external BTB looked up with the same address.
- Generates the bubble_1 qualifier that fetch2 uses to discard slot 1 of a packet.

---
 rtl/fetch1.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch1.sv
// fetch1: first fetch stage of the dual-issue front end.
// Owns the fetch PC and drives the instruction-memory address. Applies
// redirects from the branch unit and from decode, and follows BTB
// predictions. It also registers the slot-0 PC, the packet-valid flag and
// the slot-1 bubble qualifier that fetch2 needs one cycle later.
// Optional build macro FETCH1_PERF_CNT_EN adds saturating counters for
// redirect cycles and inserted slot-1 bubbles.
module fetch1 #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        branch_mispred_i,
  input  logic [31:0] branch_target_i,
  input  logic        wasnt_branch_i,
  input  logic [31:0] wasnt_branch_target_i,
  input  logic        pred_taken_i,
  input  logic        pred_slot_i,
  input  logic [31:0] pred_target_i,
  output logic [31:0] iaddr_o,
  output logic        fetch_valid_o,
  output logic [31:0] pc0_o,
  output logic [31:0] pc1_o,
  output logic        bubble_1_o
`ifdef FETCH1_PERF_CNT_EN
  ,
  output logic [31:0] perf_redirects_o,
  output logic [31:0] perf_bubbles_o
`endif
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_f2_q, pc_f2_d;
  logic        bubble_1_q, bubble_1_d;
  logic        fetch_valid_q, fetch_valid_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        load_f2;

  // Next-state logic: PC selection, boot sequencing and fetch2-side loads.
  always_comb begin
    // NOTE: every signal gets a default at the top of the block so that no
    // path leaves it unassigned; that is what keeps this logic latch-free.
    state_d         = state_q;
    pc_d            = pc_q;
    pc_f2_d         = pc_f2_q;
    bubble_1_d      = bubble_1_q;
    fetch_valid_d   = fetch_valid_q;

    redirect        = branch_mispred_i | wasnt_branch_i;
    // The branch unit is older than decode, so its target wins on a tie.
    redirect_target = branch_mispred_i ? branch_target_i : wasnt_branch_target_i;
    redirect_target[1:0] = 2'b00;
    // A redirect overrides back-pressure: the stalled packet is stale anyway.
    load_f2         = ~stall_i | redirect;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    // Same PC priority in both states; BOOT only differs in packet validity.
    if (redirect) begin
      pc_d = redirect_target;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (pred_taken_i) begin
      pc_d = pred_target_i;
    end else begin
      pc_d = pc_q + PC_STEP;
    end

    if (load_f2) begin
      pc_f2_d       = pc_q;
      bubble_1_d    = pred_taken_i & ~pred_slot_i & ~redirect;
      fetch_valid_d = (state_q == RUN);
    end
  end

  // State registers; synchronous reset has priority over all inputs.
  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset_i) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      pc_f2_q       <= RESET_VECTOR;
      bubble_1_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_f2_q       <= pc_f2_d;
      bubble_1_q    <= bubble_1_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign iaddr_o       = pc_q;
  assign pc0_o         = pc_f2_q;
  assign pc1_o         = pc_f2_q + 32'd4;
  assign bubble_1_o    = bubble_1_q;
  assign fetch_valid_o = fetch_valid_q;

`ifdef FETCH1_PERF_CNT_EN
  logic [31:0] perf_redirects_q, perf_redirects_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  // Saturating event counters for redirect cycles and loaded bubbles.
  always_comb begin
    perf_redirects_d = perf_redirects_q;
    perf_bubbles_d   = perf_bubbles_q;
    if (redirect && (perf_redirects_q != 32'hFFFF_FFFF)) begin
      perf_redirects_d = perf_redirects_q + 32'd1;
    end
    if (load_f2 && bubble_1_d && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
      perf_bubbles_d = perf_bubbles_q + 32'd1;
    end
  end

  // Counter registers, cleared and frozen while reset is high.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      perf_redirects_q <= 32'd0;
      perf_bubbles_q   <= 32'd0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_bubbles_q   <= perf_bubbles_d;
    end
  end

  assign perf_redirects_o = perf_redirects_q;
  assign perf_bubbles_o   = perf_bubbles_q;
`endif

endmodule
